// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives an 8-bit R-2R DAC,
// resolves one sample MSB first and hands it on through a one-entry buffer.
module sar_adc_ctrl #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cont,
    input  logic       abort,
    input  logic       cmp_in,
    output logic [7:0] dac_out,
    output logic       busy,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    input  logic       clr_overrun
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DECIDE, DONE} state_t;

    state_t        state, state_d;
    logic [7:0]    res, res_d, dac_d, trial;
    logic [2:0]    idx, idx_d, idx_m1;
    logic [CW-1:0] cnt, cnt_d;
    logic          cmp_m, cmp_s;
    logic          load, hs;

    assign busy   = (state != IDLE);
    assign idx_m1 = idx - 3'd1;
    assign hs     = out_valid && out_ready;

    // Two-flop synchronizer for the asynchronous comparator output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_m <= 1'b0;
            cmp_s <= 1'b0;
        end else begin
            cmp_m <= cmp_in;
            cmp_s <= cmp_m;
        end
    end

    // Next-state, trial code and result update for the conversion sequence
    always_comb begin
        state_d = state;
        res_d   = res;
        idx_d   = idx;
        cnt_d   = cnt;
        dac_d   = dac_out;
        load    = 1'b0;
        trial   = res;
        if (abort && state != IDLE) begin
            state_d = IDLE;
            dac_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    dac_d = '0;
                    if ((start || cont) && !abort) begin
                        res_d   = 8'h80;
                        dac_d   = 8'h80;
                        idx_d   = 3'd7;
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) state_d = DECIDE;
                    else           cnt_d   = cnt - 1'b1;
                end
                DECIDE: begin
                    if (!cmp_s) trial[idx] = 1'b0;
                    if (idx != 3'd0) begin
                        trial[idx_m1] = 1'b1;
                        res_d   = trial;
                        dac_d   = trial;
                        idx_d   = idx_m1;
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        res_d   = trial;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    load = 1'b1;
                    if (cont) begin
                        res_d   = 8'h80;
                        dac_d   = 8'h80;
                        idx_d   = 3'd7;
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                        dac_d   = '0;
                    end
                end
            endcase
        end
    end

    // State, datapath registers and the DAC drive register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            res     <= '0;
            idx     <= '0;
            cnt     <= '0;
            dac_out <= '0;
        end else begin
            state   <= state_d;
            res     <= res_d;
            idx     <= idx_d;
            cnt     <= cnt_d;
            dac_out <= dac_d;
        end
    end

    // One-entry output buffer with sticky overwrite flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= res;
                out_valid <= 1'b1;
            end else if (hs) begin
                out_valid <= 1'b0;
            end
            if (load && out_valid && !out_ready) overrun <= 1'b1;
            else if (clr_overrun)                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator model, scoreboard on the
// sample buffer plus directed timing, abort, overrun and reset checks.
module tb_sar_adc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       abort = 1'b0;
    logic       cmp_in;
    logic [7:0] dac_out;
    logic       busy;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       overrun;
    logic       clr_overrun = 1'b0;

    logic [7:0] vin = 8'h00;
    logic [7:0] q[$];
    int         compared = 0;
    int         mismatched = 0;
    logic       pv = 1'b0;
    logic       ph = 1'b0;

    always #5 clk = ~clk;

    assign cmp_in = (vin >= dac_out);

    sar_adc_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont),
        .abort(abort), .cmp_in(cmp_in), .dac_out(dac_out), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a new sample is presented when out_valid is high and the
    // previous cycle either had no valid data or completed a handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            ph = 1'b0;
        end else begin
            if (out_valid && (!pv || ph)) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_sample: got %0h expected none",
                             out_data);
                end else begin
                    check("sample", {24'd0, out_data}, {24'd0, q.pop_front()});
                end
            end
            pv = out_valid;
            ph = out_valid && out_ready;
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_conv(input logic [7:0] v);
        vin = v;
        q.push_back(v);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] trials [8] = '{8'h80, 8'h40, 8'h60, 8'h50,
                               8'h58, 8'h5C, 8'h5A, 8'h5B};

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        #3;
        check("rst_dac", {24'd0, dac_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Trial sequence, latency, start pulses while busy ignored
        vin = 8'h5A;
        q.push_back(8'h5A);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                repeat (5) @(posedge clk);
                #1;
            end
            check($sformatf("trial%0d", k), {24'd0, dac_out},
                  {24'd0, trials[k]});
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
        end
        repeat (5) @(posedge clk);
        #1 check("valid_e40", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 check("valid_e41", {31'd0, out_valid}, 32'd1);
        check("data_e41", {24'd0, out_data}, 32'h5A);
        @(posedge clk);
        #1 check("busy_after", {31'd0, busy}, 32'd0);
        check("dac_idle", {24'd0, dac_out}, 32'd0);
        repeat (2) @(negedge clk);

        // Boundary codes
        run_conv(8'h00);
        run_conv(8'hFF);
        run_conv(8'h80);

        // Continuous with stalled consumer -> overrun
        out_ready = 1'b0;
        vin = 8'h33;
        q.push_back(8'h33);
        @(negedge clk);
        cont = 1'b1;
        n = 0;
        while (!overrun && n < 120) begin
            @(negedge clk);
            n++;
        end
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("ovr_valid", {31'd0, out_valid}, 32'd1);
        check("ovr_data", {24'd0, out_data}, 32'h33);
        cont = 1'b0;
        wait_idle(60);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_clr", {31'd0, overrun}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain", {31'd0, out_valid}, 32'd0);

        // Continuous with ready consumer -> no overrun
        q.push_back(8'h33);
        @(negedge clk);
        cont = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("cont_first", q.size(), 32'd0);
        @(negedge clk);
        q.push_back(8'h33);
        cont = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);
        check("cont_no_ovr", {31'd0, overrun}, 32'd0);

        // Abort during bit 4 with a pending sample
        out_ready = 1'b0;
        run_conv(8'hC4);
        vin = 8'h11;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (17) @(posedge clk);
        #1 check("abort_busy_pre", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dac", {24'd0, dac_out}, 32'd0);
        check("abort_valid", {31'd0, out_valid}, 32'd1);
        check("abort_data", {24'd0, out_data}, 32'hC4);
        out_ready = 1'b1;
        run_conv(8'h11);

        // Handshake exactly on the load edge -> no overrun
        out_ready = 1'b0;
        run_conv(8'h3C);
        vin = 8'h96;
        q.push_back(8'h96);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("hs_load_ovr", {31'd0, overrun}, 32'd0);
        check("hs_load_valid", {31'd0, out_valid}, 32'd1);
        check("hs_load_data", {24'd0, out_data}, 32'h96);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset mid-SETTLE with a pending sample
        out_ready = 1'b0;
        run_conv(8'h2D);
        vin = 8'h77;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_dac", {24'd0, dac_out}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_data", {24'd0, out_data}, 32'd0);
        check("arst_ovr", {31'd0, overrun}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        run_conv(8'h77);
        run_conv(8'hA5);

        check("queue_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
